// File: rtl/vec_lsu_ctrl.sv
// Vector load/store unit initiator: streams strided LANES-byte vectors between
// the vector pipeline and data_mem over valid/ready handshakes.
module vec_lsu_ctrl #(
   parameter int LANES     = 6,
   parameter int MEM_WORDS = 102,
   parameter int CNT_W     = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_store,
   input  logic [31:0]           cmd_base,
   input  logic [15:0]           cmd_stride,
   input  logic [CNT_W-1:0]      cmd_count,
   input  logic                  wdata_valid,
   output logic                  wdata_ready,
   input  logic [LANES-1:0][7:0] wdata,
   output logic                  rdata_valid,
   input  logic                  rdata_ready,
   output logic [LANES-1:0][7:0] rdata,
   output logic                  done,
   output logic                  err,
   output logic [31:0]           mem_A,
   output logic                  mem_WE,
   output logic [LANES-1:0][7:0] mem_WD,
   input  logic [LANES-1:0][7:0] mem_RD
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_STORE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [31:0]      addr;
   logic [15:0]      stride;
   logic [CNT_W-1:0] remaining;
   logic             armed;

   logic        accept;
   logic        in_range;
   logic        load_beat;
   logic        store_beat;
   logic        last_beat;
   logic [31:0] step;
   logic        unused_base_lo;

   assign unused_base_lo = ^cmd_base[1:0];
   assign accept     = cmd_valid & cmd_ready;
   assign in_range   = (addr[31:14] == 18'd0) && (addr[13:2] < 12'(MEM_WORDS));
   assign step       = {{14{stride[15]}}, stride, 2'b00};
   assign last_beat  = (remaining == CNT_W'(1));
   // The first LOAD cycle only presents the address; capture starts the cycle after.
   assign load_beat  = (state == S_LOAD) && in_range && armed && (!rdata_valid || rdata_ready);
   assign store_beat = (state == S_STORE) && in_range && wdata_valid;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (!accept) begin
               state_nxt = S_IDLE;
            end else if (cmd_count == {CNT_W{1'b0}}) begin
               state_nxt = S_DONE;
            end else if (cmd_store) begin
               state_nxt = S_STORE;
            end else begin
               state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            if (!in_range || (load_beat && last_beat)) begin
               state_nxt = S_DONE;
            end else begin
               state_nxt = S_LOAD;
            end
         end
         S_STORE: begin
            if (!in_range || (store_beat && last_beat)) begin
               state_nxt = S_DONE;
            end else begin
               state_nxt = S_STORE;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      cmd_ready   = 1'b0;
      done        = 1'b0;
      wdata_ready = 1'b0;
      mem_WE      = 1'b0;
      mem_A       = 32'd0;
      mem_WD      = '0;
      case (state)
         S_IDLE:  cmd_ready = !rdata_valid;
         S_LOAD:  mem_A = addr;
         S_STORE: begin
            mem_A       = addr;
            wdata_ready = in_range;
            mem_WE      = wdata_valid && in_range;
            mem_WD      = wdata;
         end
         S_DONE:  done = 1'b1;
         default: cmd_ready = 1'b0;
      endcase
   end

   // Command datapath: address walk, beat counter, sticky range error
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr      <= 32'd0;
         stride    <= 16'd0;
         remaining <= {CNT_W{1'b0}};
         armed     <= 1'b0;
         err       <= 1'b0;
      end else if (accept) begin
         addr      <= {cmd_base[31:2], 2'b00};
         stride    <= cmd_stride;
         remaining <= cmd_count;
         armed     <= 1'b0;
         err       <= 1'b0;
      end else begin
         armed <= (state == S_LOAD);
         if (((state == S_LOAD) || (state == S_STORE)) && !in_range) begin
            err <= 1'b1;
         end
         if (load_beat || store_beat) begin
            addr      <= addr + step;
            remaining <= remaining - CNT_W'(1);
         end
      end
   end

   // Load data register; valid is cleared only by a consumer handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata       <= '0;
         rdata_valid <= 1'b0;
      end else if (load_beat) begin
         rdata       <= mem_RD;
         rdata_valid <= 1'b1;
      end else if (rdata_ready) begin
         rdata_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vec_lsu_ctrl.sv
// Self-checking bench for vec_lsu_ctrl: directed scenarios plus random commands
// checked against an address-list / memory-image reference model.
module tb_vec_lsu_ctrl;
   localparam int MEM_WORDS = 102;

   logic            clk = 1'b0;
   logic            rst;
   logic            cmd_valid, cmd_ready, cmd_store;
   logic [31:0]     cmd_base;
   logic [15:0]     cmd_stride;
   logic [7:0]      cmd_count;
   logic            wdata_valid, wdata_ready;
   logic [5:0][7:0] wdata;
   logic            rdata_valid, rdata_ready;
   logic [5:0][7:0] rdata;
   logic            done, err;
   logic [31:0]     mem_A;
   logic            mem_WE;
   logic [5:0][7:0] mem_WD, mem_RD;

   logic [47:0] mem     [0:4095];
   logic [47:0] ref_mem [0:4095];
   int n_cmp = 0;
   int n_bad = 0;

   vec_lsu_ctrl #(.LANES(6), .MEM_WORDS(MEM_WORDS), .CNT_W(8)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
      .cmd_base(cmd_base), .cmd_stride(cmd_stride), .cmd_count(cmd_count),
      .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
      .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
      .done(done), .err(err),
      .mem_A(mem_A), .mem_WE(mem_WE), .mem_WD(mem_WD), .mem_RD(mem_RD)
   );

   always #5 clk = ~clk;

   assign mem_RD = mem[mem_A[13:2]];
   always @(posedge clk) if (mem_WE) mem[mem_A[13:2]] <= mem_WD;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs();
      check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      check_eq("rst_rvalid", 64'(rdata_valid), 64'd0);
      check_eq("rst_rdata", 64'(rdata), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_eq("rst_err", 64'(err), 64'd0);
      check_eq("rst_wready", 64'(wdata_ready), 64'd0);
      check_eq("rst_we", 64'(mem_WE), 64'd0);
      check_eq("rst_addr", 64'(mem_A), 64'd0);
      check_eq("rst_wd", 64'(mem_WD), 64'd0);
   endtask

   // One command from accept to drained rdata, scored against the reference model.
   task automatic run_cmd(input bit st, input logic [31:0] base, input logic [15:0] stride,
                          input int cnt, input logic [47:0] pat, input int bp, input int abort_at);
      int          exp_idx[$];
      logic [47:0] wq[$];
      bit          exp_err = 1'b0;
      logic [31:0] a = base & 32'hFFFF_FFFC;
      int          s = $signed(stride);
      int it = 0, acc_it = -1, fv_it = -1, done_it = -1;
      int ndone = 0, nb = 0, nl = 0, hold = 0;
      bit acc = 1'b0, prev_stall = 1'b0, aborted = 1'b0;
      logic [47:0] prev_rd = 48'd0;
      logic [31:0] prev_a = 32'd0;

      for (int i = 0; i < cnt; i++) begin
         if (a >= 32'(MEM_WORDS * 4)) begin
            exp_err = 1'b1;
            break;
         end
         exp_idx.push_back(int'(a / 4));
         a = a + 32'(s * 4);
      end
      for (int i = 0; i < cnt; i++) begin
         if (pat != 48'd0) wq.push_back(pat + 48'(i));
         else              wq.push_back({16'($urandom), 32'($urandom)});
      end

      while (1) begin
         @(negedge clk);
         if (abort_at > 0 && nb == abort_at) begin
            wdata_valid = 1'b1;
            wdata = wq[nb];
            #1;
            rst = 1'b1;
            #1;
            check_reset_outputs();
            @(negedge clk);
            rst = 1'b0;
            aborted = 1'b1;
            break;
         end
         cmd_valid  = !acc;
         cmd_store  = st;
         cmd_base   = base;
         cmd_stride = stride;
         cmd_count  = 8'(cnt);
         if (st) begin
            wdata_valid = (nb < wq.size()) && (($urandom % 4) != 0);
            wdata = (nb < wq.size()) ? wq[nb] : 48'd0;
         end else begin
            wdata_valid = ($urandom % 2) == 0;
            wdata = {16'($urandom), 32'($urandom)};
         end
         if (bp != 0 && fv_it >= 0 && hold < 3) begin
            rdata_ready = 1'b0;
            hold++;
         end else begin
            rdata_ready = (bp != 0) ? 1'b1 : (($urandom % 3) != 0);
         end
         #1;
         if (!acc && cmd_ready) begin
            acc = 1'b1;
            acc_it = it;
         end
         if (wdata_valid && wdata_ready) begin
            if (nb < exp_idx.size()) begin
               check_eq("st_we", 64'(mem_WE), 64'd1);
               check_eq("st_addr", 64'(mem_A), 64'(exp_idx[nb] * 4));
               check_eq("st_wd", 64'(mem_WD), 64'(wq[nb]));
               ref_mem[exp_idx[nb]] = wq[nb];
            end else begin
               check_eq("st_extra_beat", 64'(nb), 64'(exp_idx.size() - 1));
            end
            nb++;
         end else if (mem_WE) begin
            check_eq("we_spurious", 64'(mem_WE), 64'd0);
         end
         if (prev_stall) begin
            check_eq("bp_rvalid_hold", 64'(rdata_valid), 64'd1);
            check_eq("bp_rdata_hold", 64'(rdata), 64'(prev_rd));
            if (prev_a != 32'd0 && prev_a < 32'(MEM_WORDS * 4))
               check_eq("bp_addr_hold", 64'(mem_A), 64'(prev_a));
         end
         if (acc && rdata_valid && fv_it < 0) begin
            fv_it = it;
            if (exp_idx.size() > 0) check_eq("load_latency", 64'(it - acc_it), 64'd3);
         end
         if (rdata_valid && rdata_ready) begin
            if (nl < exp_idx.size()) check_eq("ld_data", 64'(rdata), 64'(ref_mem[exp_idx[nl]]));
            else check_eq("ld_extra_beat", 64'(nl), 64'(exp_idx.size() - 1));
            nl++;
         end
         prev_stall = rdata_valid && !rdata_ready;
         prev_rd = rdata;
         prev_a = mem_A;
         if (done) begin
            ndone++;
            done_it = it;
         end
         it++;
         if (ndone > 0 && !rdata_valid && it > done_it + 1) break;
         if (it > 600) begin
            check_eq("timeout_done_seen", 64'(ndone), 64'd1);
            break;
         end
      end
      cmd_valid = 1'b0;
      wdata_valid = 1'b0;
      if (!aborted) begin
         check_eq("done_count", 64'(ndone), 64'd1);
         check_eq("beats", 64'(st ? nb : nl), 64'(exp_idx.size()));
         check_eq("err", 64'(err), 64'(exp_err));
         if (cnt == 0) begin
            check_eq("zero_done_lat", 64'(done_it - acc_it), 64'd1);
            check_eq("zero_no_rdata", 64'(fv_it < 0), 64'd1);
         end
         @(negedge clk);
         #1;
         check_eq("done_single", 64'(done), 64'd0);
      end
   endtask

   initial begin
      logic [47:0] v;
      logic [47:0] t2_pat;
      for (int i = 0; i < 4096; i++) begin
         v = {16'($urandom), 32'($urandom)};
         mem[i] = v;
         ref_mem[i] = v;
      end
      rst = 1'b1;
      cmd_valid = 1'b0; cmd_store = 1'b0; cmd_base = 32'd0; cmd_stride = 16'd0;
      cmd_count = 8'd0; wdata_valid = 1'b0; wdata = 48'd0; rdata_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_reset_outputs();
      @(negedge clk);
      rst = 1'b0;

      // Store/load loopback at word indices 4..6
      t2_pat = 48'h0102_0304_0506;
      run_cmd(1'b1, 32'h10, 16'd1, 3, t2_pat, 0, 0);
      for (int i = 0; i < 3; i++) check_eq("t2_mem", 64'(mem[4 + i]), 64'(t2_pat + 48'(i)));
      run_cmd(1'b0, 32'h10, 16'd1, 3, 48'd0, 0, 0);
      // Backpressure
      run_cmd(1'b0, 32'h80, 16'd3, 4, 48'd0, 1, 0);
      // Zero-count commands
      run_cmd(1'b0, 32'h20, 16'd1, 0, 48'd0, 0, 0);
      run_cmd(1'b1, 32'h20, 16'd1, 0, 48'd0, 0, 0);
      // Range error at the top of memory
      run_cmd(1'b1, 32'h190, 16'd1, 3, 48'h0A0B_0C0D_0E0F, 0, 0);
      run_cmd(1'b0, 32'h190, 16'd1, 2, 48'd0, 0, 0);
      // Negative stride
      run_cmd(1'b0, 32'h28, 16'hFFFE, 3, 48'd0, 0, 0);
      // Out-of-range base and wrap below zero
      run_cmd(1'b0, 32'h0001_0000, 16'd1, 2, 48'd0, 0, 0);
      run_cmd(1'b1, 32'h4, 16'hFFFF, 4, 48'd0, 0, 0);
      // Reset mid-store, then verify only accepted beats landed
      run_cmd(1'b1, 32'h40, 16'd1, 5, 48'd0, 0, 2);
      run_cmd(1'b0, 32'h40, 16'd1, 5, 48'd0, 0, 0);
      // Random commands
      for (int n = 0; n < 40; n++) begin
         run_cmd(1'($urandom % 2), 32'($urandom_range(0, 110) * 4 + $urandom_range(0, 3)),
                 16'(int'($urandom_range(0, 8)) - 4), int'($urandom_range(0, 12)),
                 48'd0, 0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
